// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - program byte stream and instruction memory write port of the loader
interface instr_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    // master: stream producer and memory consumer; slave: the loader itself
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - assembles big-endian 16-bit words from a byte stream, checks opcodes, writes imem
// Optional LOADER_CHECKSUM_EN: a trailing XOR checksum byte is verified before completion.
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int MAX_OP = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    instr_loader_if.slave   bus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [ADDR_W:0] word_count
);
    localparam logic [3:0] op_max      = 4'(MAX_OP);
    localparam logic [1:0] code_opcode = 2'b01;
    localparam logic [1:0] code_odd    = 2'b10;
    localparam logic [1:0] code_ovf    = 2'b11;

    typedef enum logic [2:0] {
        st_idle,
        st_hi,
        st_lo,
        st_wr,
        st_done,
        st_err,
        st_ck
    } state_t;

    state_t state;
    state_t state_n;

    logic [7:0]        word_hi;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic [1:0]        code_q;

    logic              xfer;
    logic              begin_load;
    logic              hi_take;
    logic              lo_take;
    logic              lo_ok;
    logic              wr_step;
    logic              err_set;
    logic [1:0]        err_val;
    logic              we_c;
    logic              busy_c;
    logic              done_c;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
    assign bus.in_ready = (state == st_hi) || (state == st_lo) || (state == st_ck);
`else
    assign bus.in_ready = (state == st_hi) || (state == st_lo);
`endif

    assign xfer = bus.in_valid && bus.in_ready;

    always_comb begin
        state_n    = state;
        begin_load = 1'b0;
        hi_take    = 1'b0;
        lo_take    = 1'b0;
        lo_ok      = 1'b0;
        wr_step    = 1'b0;
        err_set    = 1'b0;
        err_val    = 2'b00;
        we_c       = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;

        case (state)
            st_idle: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_n    = st_hi;
                end
            end

            st_hi: begin
                busy_c = 1'b1;
                if (xfer) begin
                    hi_take = 1'b1;
                    if (bus.in_last) begin
                        err_set = 1'b1;
                        err_val = code_odd;
                        state_n = st_err;
                    end else begin
                        state_n = st_lo;
                    end
                end
            end

            st_lo: begin
                busy_c = 1'b1;
                if (xfer) begin
                    lo_take = 1'b1;
                    if (word_hi[7:4] > op_max) begin
                        err_set = 1'b1;
                        err_val = code_opcode;
                        state_n = st_err;
                    end else begin
                        lo_ok   = 1'b1;
                        state_n = st_wr;
                    end
                end
            end

            st_wr: begin
                busy_c  = 1'b1;
                we_c    = 1'b1;
                wr_step = 1'b1;
                // A final word that exactly fills memory still completes normally.
                if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_n = st_ck;
`else
                    state_n = st_done;
`endif
                end else if (addr_q == '1) begin
                    err_set = 1'b1;
                    err_val = code_ovf;
                    state_n = st_err;
                end else begin
                    state_n = st_hi;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            st_ck: begin
                busy_c = 1'b1;
                if (xfer) begin
                    if (bus.in_data == csum_q) begin
                        state_n = st_done;
                    end else begin
                        err_set = 1'b1;
                        err_val = code_ovf;
                        state_n = st_err;
                    end
                end
            end
`endif

            st_done: begin
                done_c = 1'b1;
                if (start) begin
                    begin_load = 1'b1;
                    state_n    = st_hi;
                end else begin
                    state_n    = st_idle;
                end
            end

            st_err: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_n    = st_hi;
                end
            end

            default: state_n = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= st_idle;
            word_hi <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state <= state_n;
            if (begin_load) begin
                count_q <= '0;
                addr_q  <= '0;
                err_q   <= 1'b0;
                code_q  <= 2'b00;
            end
            if (hi_take) begin
                word_hi <= bus.in_data;
            end
            // wdata only changes on a legal word so the write port stays stable outside WR
            if (lo_ok) begin
                wdata_q <= {word_hi, bus.in_data};
                last_q  <= bus.in_last;
            end
            if (wr_step) begin
                count_q <= count_q + 1'b1;
                if (addr_q != '1) begin
                    addr_q <= addr_q + 1'b1;
                end
            end
            if (err_set) begin
                err_q  <= 1'b1;
                code_q <= err_val;
            end
`ifdef LOADER_CHECKSUM_EN
            if (begin_load) begin
                csum_q <= '0;
            end else if (hi_take || lo_take) begin
                csum_q <= csum_q ^ bus.in_data;
            end
`endif
        end
    end

    assign bus.imem_we    = we_c;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = busy_c;
    assign done           = done_c;
    assign err            = err_q;
    assign err_code       = code_q;
    assign word_count     = count_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized and directed bench for instr_loader against a word-level model
module tb_instr_loader;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int OPMAX = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   word_count;

    instr_loader_if #(.ADDR_W(AW)) bus ();

    instr_loader #(.ADDR_W(AW), .MAX_OP(OPMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] got_d[$];
    int          got_a[$];
    int          got_c[$];
    int          done_total = 0;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            got_d.push_back(bus.imem_wdata);
            got_a.push_back(int'(bus.imem_addr));
            got_c.push_back(cyc);
        end
        if (done) done_total <= done_total + 1;
    end

    logic [15:0] exp_w[$];
    int          exp_code;
    bit          exp_done;
    int          exp_consumed;
    logic [7:0]  cur_ck;
    int          last_base_w;
    int          last_t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] wr_at(input int idx);
        if (idx < got_d.size()) return got_d[idx];
        return 16'hxxxx;
    endfunction

    function automatic logic [7:0] xsum(input logic [7:0] p[$]);
        logic [7:0] x = 8'h00;
        foreach (p[i]) x ^= p[i];
        return x;
    endfunction

    // Word-level reference: pair bytes, reject bad opcodes, stop on last/odd/full memory.
    task automatic model(input logic [7:0] p[$], input bit has_last);
        logic [7:0] x;
        logic [7:0] h;
        int n;
        x = 8'h00;
        n = p.size();
        exp_w.delete();
        exp_code = 0;
        exp_done = 0;
        exp_consumed = 0;
        for (int i = 0; i < n; i += 2) begin
            h = p[i];
            x ^= h;
            exp_consumed = i + 1;
            if (has_last && i == n - 1) begin
                exp_code = 2;
                return;
            end
            if (i + 1 >= n) return;
            x ^= p[i+1];
            exp_consumed = i + 2;
            if (h[7:4] > 4'(OPMAX)) begin
                exp_code = 1;
                return;
            end
            exp_w.push_back({h, p[i+1]});
            if (has_last && i + 2 == n) begin
`ifdef LOADER_CHECKSUM_EN
                exp_consumed = n + 1;
                if (cur_ck == x) exp_done = 1;
                else exp_code = 3;
`else
                exp_done = 1;
`endif
                return;
            end
            if (exp_w.size() == DEPTH) begin
                exp_code = 3;
                return;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input bit bub);
        bit   sent;
        int   tries;
        logic v;
        logic r;
        sent  = 0;
        tries = 0;
        while (!sent) begin
            bus.in_valid = !(bub && (cyc % 2 == 1));
            bus.in_data  = d;
            bus.in_last  = l;
            @(negedge clk);
            v = bus.in_valid;
            r = bus.in_ready;
            @(posedge clk);
            #1;
            sent = v && r;
            tries++;
            if (!sent && tries >= 40) begin
                check("send_timeout", 32'(sent), 1);
                sent = 1;
            end
        end
    endtask

    task automatic run_case(input string name, input logic [7:0] prog[$], input bit has_last,
                            input logic [7:0] ck, input bit bub);
        int base_w;
        int base_d;
        int n_got;
        cur_ck = ck;
        model(prog, has_last);
        base_w = got_d.size();
        base_d = done_total;
        last_base_w = base_w;
        start = 1'b1;
        @(posedge clk);
        #1;
        last_t0 = cyc;
        start = 1'b0;
        for (int i = 0; i < exp_consumed && i < prog.size(); i++)
            send_byte(prog[i], has_last && (i == prog.size() - 1), bub);
        if (exp_consumed > prog.size())
            send_byte(cur_ck, 1'($urandom_range(0, 1)), bub);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_total > base_d || err) break;
            @(posedge clk);
            #1;
        end
        check({name, ".term"}, 32'(done_total > base_d || err), 1);
        repeat (2) @(posedge clk);
        #1;
        n_got = got_d.size() - base_w;
        check({name, ".nwr"}, n_got, exp_w.size());
        for (int i = 0; i < exp_w.size() && i < n_got; i++) begin
            check($sformatf("%s.wd%0d", name, i), got_d[base_w+i], exp_w[i]);
            check($sformatf("%s.wa%0d", name, i), got_a[base_w+i], i);
        end
        check({name, ".done"}, done_total - base_d, 32'(exp_done));
        check({name, ".err"}, 32'(err), 32'(exp_code != 0));
        check({name, ".code"}, 32'(err_code), exp_code);
        check({name, ".wc"}, 32'(word_count), exp_w.size());
        check({name, ".rdy"}, 32'(bus.in_ready), 0);
        check({name, ".busy"}, 32'(busy), 0);
    endtask

    task automatic check_zero(input string name);
        check({name, ".rdy"},   32'(bus.in_ready),   0);
        check({name, ".we"},    32'(bus.imem_we),    0);
        check({name, ".addr"},  32'(bus.imem_addr),  0);
        check({name, ".wdata"}, 32'(bus.imem_wdata), 0);
        check({name, ".busy"},  32'(busy),           0);
        check({name, ".done"},  32'(done),           0);
        check({name, ".err"},   32'(err),            0);
        check({name, ".code"},  32'(err_code),       0);
        check({name, ".wc"},    32'(word_count),     0);
    endtask

    logic [7:0] prog[$];

    initial begin
        int base;
        int lat;
        logic [7:0] hi;
        int nw;
        int kind;

        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        prog.delete();
        prog.push_back(8'h20); prog.push_back(8'h12); prog.push_back(8'hC0); prog.push_back(8'h05);
        run_case("t1", prog, 1, xsum(prog), 0);
        check("t1.w0", wr_at(last_base_w), 16'h2012);
        check("t1.w1", wr_at(last_base_w + 1), 16'hC005);
        check("t1.wc2", 32'(word_count), 2);
        lat = (last_base_w < got_c.size()) ? got_c[last_base_w] - last_t0 : -1;
        check("t1.lat", lat, 2);

        prog.delete();
        prog.push_back(8'hD1); prog.push_back(8'h23);
        run_case("t2", prog, 0, 8'h00, 0);
        check("t2.code01", 32'(err_code), 1);

        prog.delete();
        prog.push_back(8'h10); prog.push_back(8'h00); prog.push_back(8'h20);
        run_case("t3", prog, 1, 8'h00, 0);
        check("t3.w0", wr_at(last_base_w), 16'h1000);
        check("t3.code10", 32'(err_code), 2);

        prog.delete();
        for (int i = 0; i < 5; i++) begin
            prog.push_back(8'h40 + 8'(i));
            prog.push_back(8'(i * 3));
        end
        run_case("t4", prog, 0, 8'h00, 0);
        check("t4.code11", 32'(err_code), 3);

        prog.delete();
        prog.push_back(8'h20); prog.push_back(8'h12); prog.push_back(8'hC0); prog.push_back(8'h05);
        run_case("t5", prog, 1, xsum(prog), 1);
        check("t5.w0", wr_at(last_base_w), 16'h2012);
        check("t5.w1", wr_at(last_base_w + 1), 16'hC005);

`ifdef LOADER_CHECKSUM_EN
        prog.delete();
        prog.push_back(8'h20); prog.push_back(8'h12);
        run_case("ck_ok", prog, 1, 8'h32, 0);
        check("ck_ok.done", 32'(err), 0);
        run_case("ck_bad", prog, 1, 8'h33, 0);
        check("ck_bad.code", 32'(err_code), 3);
        check("ck_bad.w0", wr_at(last_base_w), 16'h2012);
`endif

        base = got_d.size();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h30, 1'b0, 1);
        send_byte(8'h45, 1'b0, 1);
        send_byte(8'h51, 1'b0, 1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("rst_mid");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        bus.in_last  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("rst_mid.nwr", got_d.size() - base, 1);
        check("rst_mid.w0", wr_at(base), 16'h3045);

        for (int it = 0; it < 40; it++) begin
            nw   = $urandom_range(1, 5);
            kind = $urandom_range(0, 2);
            if (kind == 2) nw = 5;
            prog.delete();
            for (int w = 0; w < nw; w++) begin
                hi = 8'($urandom);
                if ($urandom_range(0, 3) != 0) hi[7:4] = 4'($urandom_range(0, OPMAX));
                prog.push_back(hi);
                prog.push_back(8'($urandom));
            end
            if (kind == 1) void'(prog.pop_back());
            hi = xsum(prog);
            if ($urandom_range(0, 1) == 1) hi = hi ^ 8'($urandom_range(1, 255));
            run_case($sformatf("r%0d", it), prog, kind != 2, hi, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
